// File: rtl/leaf_bft_pkg.sv
// Shared widths and the back-off FSM state type for the BFT leaf endpoint.
package leaf_bft_pkg;

  localparam int PKT_W     = 49;
  localparam int PAYLOAD_W = 48;
  localparam int VALID_BIT = 48;

  typedef enum logic {
    IDLE    = 1'b0,
    BACKOFF = 1'b1
  } bft_state_e;

endpackage

// File: rtl/leaf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// Push while full and pop while empty are ignored.
module leaf_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Qualify requests against the registered occupancy and compute next pointers/count.
  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && valid_o;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/leaf_bft_endpoint.sv
// BFT leaf endpoint: page-to-network egress through a FWFT FIFO with a
// back-off FSM that asks the page to resend dropped words, and a one-cycle
// registered network-to-page ingress path.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | page words are accepted while the FIFO has room
//   BACKOFF | FIFO overflowed; all page words dropped, resend asserted,
//           | left once occupancy drains to LOW_WM or below
module leaf_bft_endpoint
  import leaf_bft_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = FIFO_DEPTH - 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PKT_W-1:0]     din_leaf_interface2bft,
  output logic [PKT_W-1:0]     dout_leaf_bft2interface,
  output logic                 resend,
  input  logic [PAYLOAD_W-1:0] net_in_data,
  input  logic                 net_in_valid,
  output logic                 net_in_ready,
  output logic [PAYLOAD_W-1:0] net_out_data,
  output logic                 net_out_valid,
  input  logic                 net_out_ready,
  output logic [15:0]          drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bft_state_e           state_q, state_d;
  logic                 resend_q, resend_d;
  logic [15:0]          drop_q, drop_d;
  logic [PKT_W-1:0]     dout_q, dout_d;
  logic                 push, pop, page_valid;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_count;

  assign page_valid = din_leaf_interface2bft[VALID_BIT];
  assign pop        = net_out_valid && net_out_ready;

  leaf_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (din_leaf_interface2bft[PAYLOAD_W-1:0]),
    .pop_i       (pop),
    .head_o      (net_out_data),
    .valid_o     (net_out_valid),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // Back-off next state, push qualification, drop counting and ingress capture.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        push = page_valid && !fifo_full;
        if (page_valid && fifo_full) begin
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        if (fifo_count <= CW'(LOW_WM)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (page_valid && !push && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    resend_d = (state_d == BACKOFF);
    dout_d   = net_in_valid ? {1'b1, net_in_data} : '0;
  end

  // FSM, resend flag, drop counter and ingress output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      resend_q <= 1'b0;
      drop_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      resend_q <= resend_d;
      drop_q   <= drop_d;
      dout_q   <= dout_d;
    end
  end

  // The network side is never back-pressured; ready simply follows reset.
  assign net_in_ready            = reset;
  assign resend                  = resend_q;
  assign drop_count              = drop_q;
  assign dout_leaf_bft2interface = dout_q;

endmodule

// File: doc/leaf_bft_endpoint.md
LEAF_BFT_ENDPOINT -- requirements
Module: leaf_bft_endpoint

Interface
REQ-001 Parameter: FIFO_DEPTH, default 16, egress FIFO entries (power of two, >= 8).
REQ-002 Parameter: LOW_WM, default FIFO_DEPTH-4, occupancy at or below which back-off ends.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din_leaf_interface2bft  input  49  word from page: [48] valid, [47:0] payload.
REQ-006 dout_leaf_bft2interface  output  49  word to page: [48] valid, [47:0] payload.
REQ-007 resend  output  1  to page; high means page words are being dropped and must be re-sent.
REQ-008 net_in_data  input  48  payload from BFT network.
REQ-009 net_in_valid  input  1  net_in_data is valid.
REQ-010 net_in_ready  output  1  endpoint accepts net_in_data.
REQ-011 net_out_data  output  48  egress payload to BFT network.
REQ-012 net_out_valid  output  1  net_out_data is valid.
REQ-013 net_out_ready  input  1  network accepts net_out_data.
REQ-014 drop_count  output  16  saturating count of dropped page words.

Function
REQ-015 Egress push: the block SHALL write din[47:0] into the FIFO when din[48]=1, FSM=IDLE and count<FIFO_DEPTH.
REQ-016 Fullness is judged on the registered count. A push at full SHALL be rejected even if a pop occurs in the same cycle.
REQ-017 Egress pop: the FIFO is first-word-fall-through. net_out_valid SHALL equal (count!=0) and net_out_data SHALL equal the head. Pop SHALL occur on net_out_valid & net_out_ready.
REQ-018 A simultaneous push and pop with 0<count<FIFO_DEPTH SHALL leave count unchanged and preserve order.
REQ-019 Back-off FSM states: IDLE and BACKOFF.
- IDLE -> BACKOFF when din[48]=1 and count=FIFO_DEPTH.
- BACKOFF -> IDLE when count<=LOW_WM.
REQ-020 resend SHALL be registered and high exactly in the cycles when FSM=BACKOFF. It rises one cycle after the rejected word.
REQ-021 Every valid page word not pushed (rejected at full, or arriving in BACKOFF) SHALL increment drop_count by 1. drop_count saturates at 16'hFFFF.
REQ-022 Ingress: net_in_ready SHALL be 1 whenever reset is deasserted; no backpressure is applied toward the network.
REQ-023 Ingress latency is 1 cycle: dout_leaf_bft2interface SHALL be registered to {1'b1, net_in_data} when net_in_valid, and to 49'h0 otherwise.
REQ-024 Egress and ingress paths SHALL be independent; activity on one never stalls the other.

Reset
REQ-025 Asserting reset SHALL asynchronously clear:
- FIFO pointers and count to 0
- FSM to IDLE
- resend, net_out_valid, net_in_ready and drop_count to 0
- dout_leaf_bft2interface to 49'h0
REQ-026 Reset mid-packet-stream SHALL discard all buffered egress words, with no partial delivery after release.
REQ-027 On the first rising edge after release, normal operation SHALL begin.

Structure
REQ-028 Package leaf_bft_pkg SHALL hold:
- PKT_W=49, PAYLOAD_W=48, VALID_BIT=48
- the FSM state enum {IDLE, BACKOFF}
REQ-029 The egress FIFO SHALL be the sub-module leaf_sync_fifo (parameterised depth/width, FWFT, count output). FSM, counter and ingress register stay in the top.

Verification
REQ-030 Stream 10 page words 0x1..0xA with net_out_ready=1 -> net_out emits 0x1..0xA in order, each one cycle after push; resend stays 0; drop_count=0.
REQ-031 net_out_ready=0, push 17 words -> count=16; word 17 is dropped; resend is high from the next cycle; drop_count=1.
REQ-032 Continuing from REQ-031, push 3 more words during BACKOFF, then set net_out_ready=1 -> drop_count=4. resend falls in the cycle after count reaches 12. The first 16 words emerge intact.
REQ-033 At count=16, push and pop in the same cycle -> push rejected, count=15, FSM=BACKOFF.
REQ-034 net_in_valid pulses with 0x0000_1234_5678 -> dout=49'h1_0000_1234_5678 one cycle later, then 49'h0.
REQ-035 Assert reset with 5 words buffered and resend high -> all outputs are 0 immediately. After release, net_out_valid stays 0 until a new push.
